// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - 2-bit saturating-counter branch history table with mispredict redirect
module branch_predictor_bht #(
   parameter int IDX_BITS = 6,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_valid,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            pred_taken,
   input  logic            res_valid,
   input  logic [XLEN-1:0] res_pc,
   input  logic            res_taken,
   input  logic            res_pred,
   input  logic [XLEN-1:0] res_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     branch_count,
   output logic [31:0]     mispredict_count
);
   localparam int DEPTH = 1 << IDX_BITS;

   logic [1:0]          table_q [DEPTH];
   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] res_idx;
   logic [1:0]          res_ctr;
   logic [1:0]          res_ctr_d;
   logic                mispredict;

   logic                redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
   logic [31:0]         branch_count_q, branch_count_d;
   logic [31:0]         mispredict_count_q, mispredict_count_d;

   logic                unused_fetch_bits;

   assign fetch_idx = fetch_pc[IDX_BITS+1:2];
   assign res_idx   = res_pc[IDX_BITS+1:2];
   assign res_ctr   = table_q[res_idx];

   // Lookup reads the registered table, so a same-cycle update is not bypassed.
   assign pred_taken = fetch_valid & table_q[fetch_idx][1];

   // Mispredict is judged against the prediction actually used, not the table.
   assign mispredict = res_valid & (res_taken != res_pred);

   always_comb begin
      res_ctr_d = res_ctr;
      if (res_taken) begin
         if (res_ctr != 2'b11) res_ctr_d = res_ctr + 2'd1;
      end else begin
         if (res_ctr != 2'b00) res_ctr_d = res_ctr - 2'd1;
      end

      redirect_valid_d = mispredict;
      redirect_pc_d    = redirect_pc_q;
      if (mispredict) redirect_pc_d = res_taken ? res_target : res_pc + XLEN'(4);

      branch_count_d     = branch_count_q + {31'd0, res_valid};
      mispredict_count_d = mispredict_count_q + {31'd0, mispredict};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= 2'b01;
      end else if (res_valid) begin
         table_q[res_idx] <= res_ctr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_valid_q   <= 1'b0;
         redirect_pc_q      <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         redirect_valid_q   <= redirect_valid_d;
         redirect_pc_q      <= redirect_pc_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

   // Tag-less table: upper and byte-offset PC bits never take part in lookup.
   assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_BITS+2], fetch_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - scoreboard bench for branch_predictor_bht
module tb_branch_predictor_bht;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic        pred_taken;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = '0;
   logic        res_taken = 1'b0;
   logic        res_pred = 1'b0;
   logic [31:0] res_target = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int errors = 0;
   int checks = 0;
   bit          pred_q[$];
   logic [31:0] redir_q[$];

   branch_predictor_bht #(.IDX_BITS(6), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
      .res_pred(res_pred), .res_target(res_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected values pushed here; the monitor pops them when the DUT presents output.
   task automatic drive(input bit fv, input logic [31:0] fpc, input bit ep,
                        input bit rv, input logic [31:0] rpc, input bit rt, input bit rp,
                        input logic [31:0] tgt, input logic [31:0] erpc);
      @(posedge clk); #1;
      fetch_valid = fv; fetch_pc = fpc;
      res_valid = rv; res_pc = rpc; res_taken = rt; res_pred = rp; res_target = tgt;
      if (fv) pred_q.push_back(ep);
      if (rv && (rt != rp)) redir_q.push_back(erpc);
   endtask

   task automatic idle();
      drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic check_counts(input string tag, input logic [31:0] eb, input logic [31:0] em);
      check({tag, "_branch_count"}, branch_count, eb);
      check({tag, "_mispredict_count"}, mispredict_count, em);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      fetch_valid = 0; res_valid = 0;
      @(negedge clk);
      @(negedge clk); #2;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (fetch_valid) begin
            if (pred_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL pred_unexpected: got lookup with no expectation, pred=%0d", pred_taken);
            end else begin
               check("pred_taken", 32'(pred_taken), 32'(pred_q.pop_front()));
            end
         end else begin
            check("pred_idle_zero", 32'(pred_taken), 32'h0);
         end
         if (redirect_valid) begin
            if (redir_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL redirect_unexpected: got pulse pc=0x%08h expected no pulse", redirect_pc);
            end else begin
               check("redirect_pc", redirect_pc, redir_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("reset_redirect_valid", 32'(redirect_valid), 32'h0);
      check("reset_redirect_pc", redirect_pc, 32'h0);
      check_counts("reset", 32'd0, 32'd0);

      // Train entry 0 to strong-T, then reset with a redirect in flight.
      drive(0, 32'h0, 0, 1, 32'h100, 1, 1, 32'h180, 32'h0);
      drive(0, 32'h0, 0, 1, 32'h100, 1, 1, 32'h180, 32'h0);
      @(posedge clk); #1;
      res_valid = 1; res_pc = 32'h40; res_taken = 1; res_pred = 0; res_target = 32'h80;
      @(posedge clk); #1;
      res_valid = 0;
      check("inflight_redirect_valid", 32'(redirect_valid), 32'h1);
      check_counts("pre_reset", 32'd3, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("midrst_redirect_valid", 32'(redirect_valid), 32'h0);
      check("midrst_redirect_pc", redirect_pc, 32'h0);
      check_counts("midrst", 32'd0, 32'd0);
      @(negedge clk); #2 rst = 1'b0;

      // Table back to weak-NT everywhere.
      drive(1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

      // Training at 0x100: 01->10->11->10->01.
      drive(1, 32'h100, 0, 1, 32'h100, 1, 0, 32'h180, 32'h180);
      drive(1, 32'h100, 1, 1, 32'h100, 1, 1, 32'h180, 32'h0);
      drive(1, 32'h100, 1, 1, 32'h100, 0, 1, 32'h180, 32'h104);
      drive(1, 32'h100, 1, 1, 32'h100, 0, 1, 32'h180, 32'h104);
      drive(1, 32'h100, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
      check_counts("train", 32'd4, 32'd3);

      // Saturation at 0x200 (aliases entry 0): floor at 00, then one step up.
      for (int i = 0; i < 5; i++) drive(1, 32'h200, 0, 1, 32'h200, 0, 0, 32'h300, 32'h0);
      drive(1, 32'h200, 0, 1, 32'h200, 1, 0, 32'h300, 32'h300);
      drive(1, 32'h200, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
      check_counts("saturate", 32'd10, 32'd4);

      // Taken mispredict, then fall-through at top of address space (wraps to 0).
      drive(0, 32'h0, 0, 1, 32'h40, 1, 0, 32'h80, 32'h80);
      idle();
      check_counts("taken_mp", 32'd11, 32'd5);
      drive(0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h1234, 32'h0);
      idle();
      check("wrap_redirect_pc", redirect_pc, 32'h0);

      // Same-cycle update/lookup at index 3, then alias 0x10C sees new value.
      drive(1, 32'h0C, 0, 1, 32'h0C, 1, 0, 32'h20, 32'h20);
      drive(1, 32'h10C, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
      check_counts("hazard", 32'd13, 32'd7);
      idle();

      // Stats: 10 resolves, 3 mispredicts (3rd and 4th back-to-back).
      do_reset();
      drive(0, 32'h0, 0, 1, 32'h1000, 1, 1, 32'h2000, 32'h0);
      drive(0, 32'h0, 0, 1, 32'h1004, 0, 0, 32'h2000, 32'h0);
      drive(0, 32'h0, 0, 1, 32'h1008, 1, 0, 32'h2000, 32'h2000);
      drive(0, 32'h0, 0, 1, 32'h100C, 0, 1, 32'h2000, 32'h1010);
      drive(0, 32'h0, 0, 1, 32'h1010, 1, 1, 32'h2000, 32'h0);
      drive(0, 32'h0, 0, 1, 32'h1014, 0, 0, 32'h2000, 32'h0);
      drive(0, 32'h0, 0, 1, 32'h1018, 1, 1, 32'h2000, 32'h0);
      drive(0, 32'h0, 0, 1, 32'h101C, 0, 1, 32'h2000, 32'h1020);
      drive(0, 32'h0, 0, 1, 32'h1020, 0, 0, 32'h2000, 32'h0);
      drive(0, 32'h0, 0, 1, 32'h1024, 1, 1, 32'h2000, 32'h0);
      idle();
      idle();
      check_counts("stats", 32'd10, 32'd3);
      check("hold_redirect_pc", redirect_pc, 32'h1020);
      check("hold_redirect_valid", 32'(redirect_valid), 32'h0);

      idle();
      @(posedge clk); #1;
      check("pred_queue_drained", pred_q.size(), 32'd0);
      check("redirect_queue_drained", redir_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
